lsense_trace_buf: RTL and testbench

LSENSE_TRACE_BUF -- requirements
Module: lsense_trace_buf

---
 rtl/lsense_trace_buf_if.sv | 11 +
 rtl/lsense_trace_buf.sv | 141 ++++++++++++++
 tb/tb_lsense_trace_buf.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsense_trace_buf_if.sv
// Readout stream of the trace buffer: one count sample per transfer over valid/ready.
interface lsense_trace_buf_if #(
    parameter int CNTW = 7
);
    logic [CNTW-1:0] datout;
    logic            datvalid;
    logic            datready;

    modport master (output datout, output datvalid, input datready);
    modport slave  (input datout, input datvalid, output datready);
endinterface

// File: rtl/lsense_trace_buf.sv
// Delay-line sensor trace buffer: counts the ones in each sensor word, captures
// DEPTH consecutive counts after a trigger into a block RAM, then streams them out.
module lsense_trace_buf #(
    parameter int LINELEN = 64,
    parameter int DEPTH   = 256,
    parameter int CNTW    = 7
) (
    input  logic               clkin,
    input  logic               rstnin,
    input  logic [LINELEN-1:0] sensin,
    input  logic               trigin,
    lsense_trace_buf_if.master rd,
    output logic               busy,
    output logic               done,
    output logic [1:0]         calerr
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, CAPTURE, DRAIN} state_t;

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    logic [LINELEN-1:0] r_sens_neg;
    logic [LINELEN-1:0] r_sens;
    logic [CNTW-1:0]    w_cnt;
    logic [CNTW-1:0]    r_cnt;
    state_t             r_state, w_state_nxt;
    logic               w_we, w_trig, w_wr_last;
    logic [AW-1:0]      r_wr_addr, r_rd_addr;
    logic               r_rd_fin, r_vld, r_done;
    logic               w_re, w_xfer, w_last_xfer;
    logic [1:0]         r_cal;
    logic [CNTW-1:0]    r_mem [DEPTH];
    logic [CNTW-1:0]    r_q;

    // Reset asserts at once, releases two rising edges later.
    always_ff @(posedge clkin or negedge rstnin) begin
        if (!rstnin) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // The sensor line is launched on the rising edge, so it is caught half a cycle later.
    always_ff @(negedge clkin) begin
        r_sens_neg <= sensin;
    end

    // Bring the sensor word back into the rising-edge domain.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n) r_sens <= '0;
        else          r_sens <= r_sens_neg;
    end

    // Population count: bubbles in the thermometer code still count correctly.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < LINELEN; i++) w_cnt = w_cnt + CNTW'(r_sens[i]);
    end

    // Register the count; sample for edge k is in r_cnt after edge k+1.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n) r_cnt <= '0;
        else          r_cnt <= w_cnt;
    end

    // FSM state register.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state: FILL is one cycle, covering the count register stage.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (trigin)      w_state_nxt = FILL;
            FILL:                     w_state_nxt = CAPTURE;
            CAPTURE: if (w_wr_last)   w_state_nxt = DRAIN;
            DRAIN:   if (w_last_xfer) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy   = (r_state != IDLE);
        w_we   = (r_state == CAPTURE);
        w_trig = (r_state == IDLE) && trigin;
    end

    assign w_wr_last   = (r_wr_addr == AW'(DEPTH - 1));
    assign w_xfer      = r_vld && rd.datready;
    assign w_last_xfer = w_xfer && r_rd_fin;
    // Read only when the output slot is free or being emptied this cycle.
    assign w_re        = (r_state == DRAIN) && !r_rd_fin && (!r_vld || w_xfer);

    // Write address wraps to 0 after the last capture write.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n)  r_wr_addr <= '0;
        else if (w_we) r_wr_addr <= r_wr_addr + 1'b1;
    end

    // Read side: address, all-issued flag, output valid and end-of-trace pulse.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_addr <= '0;
            r_rd_fin  <= 1'b0;
            r_vld     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_re) r_rd_addr <= r_rd_addr + 1'b1;
            if (w_last_xfer)                              r_rd_fin <= 1'b0;
            else if (w_re && r_rd_addr == AW'(DEPTH - 1)) r_rd_fin <= 1'b1;
            if (w_re)        r_vld <= 1'b1;
            else if (w_xfer) r_vld <= 1'b0;
            r_done <= w_last_xfer;
        end
    end

    // Sticky calibration flags; a saturated write beats the trigger clear.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n) r_cal <= 2'b00;
        else          r_cal <= (w_trig ? 2'b00 : r_cal)
                             | {w_we && (r_cnt == CNTW'(LINELEN)), w_we && (r_cnt == '0)};
    end

    // Sample RAM write port (no reset so it maps onto block RAM).
    always_ff @(posedge clkin) begin
        if (w_we) r_mem[r_wr_addr] <= r_cnt;
    end

    // Sample RAM read port; q holds while not re-read, keeping datout stable on stalls.
    always_ff @(posedge clkin) begin
        if (w_re) r_q <= r_mem[r_rd_addr];
    end

    assign rd.datout   = r_vld ? r_q : '0;
    assign rd.datvalid = r_vld;
    assign done        = r_done;
    assign calerr      = r_cal;
endmodule

// File: tb/tb_lsense_trace_buf.sv
// Bench for lsense_trace_buf: table of trace scenarios plus storm, mid-reset and DEPTH=4 sequences.
module tb_lsense_trace_buf;
    localparam int D = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, trig, trig4, busy, done, busy4, done4;
    logic [63:0] sens, sens4;
    logic [1:0]  cal, cal4;

    lsense_trace_buf_if #(.CNTW(7)) rif ();
    lsense_trace_buf_if #(.CNTW(7)) rif4 ();

    lsense_trace_buf #(.LINELEN(64), .DEPTH(D), .CNTW(7)) dut (
        .clkin(clk), .rstnin(rstn), .sensin(sens), .trigin(trig), .rd(rif),
        .busy(busy), .done(done), .calerr(cal));

    lsense_trace_buf #(.LINELEN(64), .DEPTH(4), .CNTW(7)) dut4 (
        .clkin(clk), .rstnin(rstn), .sensin(sens4), .trigin(trig4), .rd(rif4),
        .busy(busy4), .done(done4), .calerr(cal4));

    int total = 0, bad = 0;
    int ecnt = 0, mode = 0, base = 0, done_cnt = 0, k2;
    bit bp = 1'b0, storm_arm = 1'b0, pstall = 1'b0;
    logic [6:0] pdat, e7;
    logic [6:0] expq[$];

    typedef struct { int mode; bit bp; logic [1:0] cal; } vec_t;
    vec_t vt[4];

    function automatic logic [63:0] therm(int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Bubbly pattern that never reaches 0 or 64 ones.
    function automatic logic [63:0] hashv(int e);
        logic [31:0] a, b;
        a = 32'(e) * 32'h9E3779B1;
        b = {a[15:0], a[31:16]} ^ 32'h5bd1e995;
        return ({a, b} | 64'h1) & ~64'h2;
    endfunction

    function automatic int ramp(int e);
        return ((e - base) % 65 + 65) % 65;
    endfunction

    function automatic logic [63:0] sens_of(int e);
        case (mode)
            0:       return therm(ramp(e));
            1:       return 64'h0000_0000_0000_0F0F;
            2:       return hashv(e);
            default: return '1;
        endcase
    endfunction

    function automatic logic [6:0] exp_of(int e);
        case (mode)
            0:       return 7'(ramp(e));
            1:       return 7'd8;
            2:       return 7'($countones(hashv(e)));
            default: return 7'd64;
        endcase
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Driver: sensin for the next rising edge and datready, changed just after each edge.
    initial begin
        sens = '0;
        rif.datready = 1'b1;
        forever begin
            @(posedge clk);
            ecnt++;
            #1;
            sens = sens_of(ecnt + 1);
            rif.datready = bp ? (((ecnt % 4 == 0) || (ecnt % 4 == 3)) ^ ($urandom_range(0, 3) == 0)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, stall stability, done accounting.
    always @(negedge clk) begin
        if (pstall) begin
            chk("hold_valid", rif.datvalid, 1);
            chk("hold_data", rif.datout, pdat);
        end
        if (rif.datvalid && rif.datready) begin
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL extra_sample: got %0d want none", rif.datout);
            end else begin
                e7 = expq.pop_front();
                chk("sample", rif.datout, e7);
            end
        end
        if (rif.datvalid) chk("valid_needs_busy", busy, 1);
        if (done) begin
            done_cnt++;
            chk("busy_at_done", busy, 0);
            if (storm_arm) begin
                storm_arm = 1'b0;
                k2 = ecnt + 1;
                for (int n = 0; n < D; n++) expq.push_back(exp_of(k2 + n));
            end
        end
        pstall = rif.datvalid && !rif.datready;
        pdat   = rif.datout;
    end

    task automatic wait_done(int target, int lim);
        int c = 0;
        while (done_cnt < target && c < lim) begin
            @(negedge clk);
            c++;
        end
        if (c >= lim) chk("done_timeout", done_cnt, target);
    endtask

    // Arm expectations, then pulse trigin so it is seen at edge 'base'.
    task automatic start_trace(int m, bit b, bit push, bit hold);
        @(negedge clk);
        mode = m; bp = b; base = ecnt + 2;
        if (push) for (int n = 0; n < D; n++) expq.push_back(exp_of(base + n));
        @(posedge clk); #1 trig = 1'b1;
        @(posedge clk); #1 if (!hold) trig = 1'b0;
    endtask

    task automatic run_trace(int m, bit b, logic [1:0] ecal);
        done_cnt = 0;
        start_trace(m, b, 1'b1, 1'b0);
        chk("busy_after_trig", busy, 1);
        wait_done(1, 3000);
        repeat (2) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("samples_left", expq.size(), 0);
        chk("calerr", cal, ecal);
        chk("busy_idle", busy, 0);
        expq.delete();
    endtask

    initial begin
        int n4;
        bit seen4;
        vt[0] = '{0, 1'b0, 2'b11};   // ramp, ready high
        vt[1] = '{1, 1'b0, 2'b00};   // constant bubbles -> 8
        vt[2] = '{2, 1'b1, 2'b00};   // random bubbly words, backpressure
        vt[3] = '{0, 1'b1, 2'b11};   // ramp under backpressure

        rstn = 1'b0; trig = 1'b0; trig4 = 1'b0; sens4 = '1;
        rif4.datready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", rif.datvalid, 0);
        chk("rst_dat", rif.datout, 0);
        chk("rst_done", done, 0);
        chk("rst_cal", cal, 0);
        rstn = 1'b1;
        repeat (4) @(posedge clk);

        foreach (vt[i]) run_trace(vt[i].mode, vt[i].bp, vt[i].cal);

        // Reset after 100 capture writes: trace abandoned, no done.
        done_cnt = 0;
        start_trace(0, 1'b0, 1'b0, 1'b0);
        repeat (100) @(posedge clk);
        #1 chk("cal_before_rst", cal, 3);
        rstn = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", rif.datvalid, 0);
        chk("mrst_dat", rif.datout, 0);
        chk("mrst_cal", cal, 0);
        repeat (3) @(posedge clk); #1 rstn = 1'b1;
        repeat (4) @(posedge clk);
        chk("no_done_after_rst", done_cnt, 0);
        run_trace(0, 1'b0, 2'b11);

        // Trigger held high: one full trace, then a second from the first IDLE cycle.
        done_cnt = 0;
        storm_arm = 1'b1;
        start_trace(0, 1'b0, 1'b1, 1'b1);
        repeat (600) @(posedge clk);
        #1 trig = 1'b0;
        wait_done(2, 3000);
        repeat (2) @(negedge clk);
        chk("storm_done_count", done_cnt, 2);
        chk("storm_samples_left", expq.size(), 0);
        chk("storm_busy", busy, 0);
        expq.delete();

        // DEPTH=4 with saturated sensor.
        n4 = 0; seen4 = 1'b0;
        @(posedge clk); #1 trig4 = 1'b1;
        @(posedge clk); #1 trig4 = 1'b0;
        for (int c = 0; c < 40 && !seen4; c++) begin
            @(negedge clk);
            if (rif4.datvalid && rif4.datready) begin
                chk("d4_sample", rif4.datout, 64);
                n4++;
            end
            if (done4) begin
                seen4 = 1'b1;
                chk("d4_busy_at_done", busy4, 0);
                chk("d4_cal", cal4, 2);
            end
        end
        chk("d4_done_seen", seen4, 1);
        chk("d4_count", n4, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
